// File: rtl/mul_share_pkg.sv
// Shared definitions for the multiplier-sharing controller: state encoding,
// multiplier step count and timeout defaults.
package mul_share_pkg;

  // Controller states: flush the multiplier counter, wait for a request, run a product.
  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // Number of cycles the iterative multiplier needs per product.
  localparam int MUL_STEPS = 33;

  // RUN cycles allowed before the sticky error flag is raised; must exceed MUL_STEPS.
  localparam int DEFAULT_TIMEOUT = 40;

  // Width of the RUN-cycle watchdog counter.
  localparam int TCNT_W = 6;

endpackage

// File: rtl/mul_share_ctrl_if.sv
// Requester-side bundle of the multiplier-sharing controller: per-requester
// level requests and packed operands in, one-hot ack and shared product out.
interface mul_share_ctrl_if #(
  parameter int N = 4
);
  logic [N-1:0]    req;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [N-1:0]    ack;
  logic [63:0]     res;

  // Requester (core issue logic) side.
  modport master (
    output req, req_a, req_b,
    input  ack, res
  );

  // Controller side.
  modport slave (
    input  req, req_a, req_b,
    output ack, res
  );
endinterface

// File: rtl/mul_share_ctrl_arbiter.sv
// Round-robin arbiter: grants the first eligible requester at or after the
// pointer, wrapping around. Purely combinational.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  // Scan from the pointer position and keep only the first hit.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    grant = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      int j;
      j = (int'(ptr) + i) % N;
      if (eligible[j] && (grant == '0)) begin
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/mul_share_ctrl.sv
// Shares one iterative 32x32->64 multiplier between N requesters. Flushes the
// multiplier step counter after reset, arbitrates round-robin, holds the
// winner's operands for the whole run and returns the product with a one-cycle
// ack to the owner. A watchdog aborts runs that never finish.
module mul_share_ctrl
  import mul_share_pkg::*;
#(
  parameter int N       = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  mul_share_ctrl_if.slave         rq,
  output logic                    ready,
  output logic                    err,
  output logic                    mul,
  input  logic                    stall,
  output logic [31:0]             op_a,
  output logic [31:0]             op_b,
  input  logic [63:0]             mul_res
);

  localparam int                IW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [TCNT_W-1:0] TLIM = TCNT_W'(TIMEOUT - 1);

  state_t            state;
  logic [N-1:0]      owner;
  logic [IW-1:0]     ptr;
  logic [TCNT_W-1:0] tcnt;

  logic [N-1:0]      eligible;
  logic [N-1:0]      grant;
  logic [IW-1:0]     gidx;
  logic [IW-1:0]     ptr_next;

  // A requester being acked this cycle still has req high; ignore it so one
  // level request is not served twice.
  assign eligible = rq.req & ~rq.ack;
  assign ptr_next = (gidx == IW'(N - 1)) ? '0 : gidx + 1'b1;

  rr_arbiter #(.N(N), .IW(IW)) u_arb (
    .eligible (eligible),
    .ptr      (ptr),
    .grant    (grant),
    .idx      (gidx)
  );

  // Controller FSM with registered multiplier and requester outputs.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // sees the values from before this edge, regardless of statement order.
    if (rst) begin
      state  <= ST_FLUSH;
      owner  <= '0;
      ptr    <= '0;
      tcnt   <= '0;
      mul    <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      ready  <= 1'b0;
      err    <= 1'b0;
      rq.ack <= '0;
      rq.res <= '0;
    end else begin
      rq.ack <= '0;
      unique case (state)
        ST_FLUSH: begin
          mul  <= 1'b1;
          op_a <= '0;
          op_b <= '0;
          // NOTE: mul is still low in the first cycle after reset, and an idle
          // multiplier reports stall=0; only a stall=0 seen while mul is high
          // means the counter has really been cleared.
          if (mul && !stall) begin
            mul   <= 1'b0;
            ready <= 1'b1;
            state <= ST_IDLE;
          end
        end

        ST_IDLE: begin
          mul <= 1'b0;
          if (eligible != '0) begin
            op_a  <= rq.req_a[32*int'(gidx) +: 32];
            op_b  <= rq.req_b[32*int'(gidx) +: 32];
            owner <= grant;
            ptr   <= ptr_next;
            tcnt  <= '0;
            mul   <= 1'b1;
            state <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (!stall) begin
            // mul is high in this final step, which re-arms the multiplier counter.
            rq.res <= mul_res;
            rq.ack <= owner;
            mul    <= 1'b0;
            state  <= ST_IDLE;
          end else if (tcnt == TLIM) begin
            err   <= 1'b1;
            ready <= 1'b0;
            state <= ST_FLUSH;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        default: begin
          ready <= 1'b0;
          state <= ST_FLUSH;
        end
      endcase
    end
  end

endmodule
